// File: rtl/sobel_window_gen.sv
// Raster-to-window stage: two line buffers plus a 3x3 shift window feeding the
// Sobel magnitude stage, with row/column tagging and end-of-frame pulse.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d, col_tag;
  logic [RW-1:0] row_q, row_d, row_tag;
  logic [7:0]    lb0_mem [IMG_WIDTH];
  logic [7:0]    lb1_mem [IMG_WIDTH];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win_q [9];
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_tag      = sof ? '0 : col_q;
    row_tag      = sof ? '0 : row_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      win_valid_d  = (row_tag >= RW'(2)) && (col_tag >= CW'(2));
      frame_done_d = (row_tag == RW'(IMG_HEIGHT - 1)) && (col_tag == CW'(IMG_WIDTH - 1));
      if (col_tag == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_tag == RW'(IMG_HEIGHT - 1)) ? '0 : row_tag + RW'(1);
      end else begin
        col_d = col_tag + CW'(1);
        row_d = row_tag;
      end
    end
  end

  assign lb1_rd = lb1_mem[col_tag];
  assign lb0_rd = lb0_mem[col_tag];

  // NOTE: line buffers carry no reset; stale lines are never exposed because
  // win_valid only rises once two fresh rows of the current frame are stored.
  // NOTE: non-blocking writes make the reads above see the old contents,
  // giving read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[col_tag] <= pix_in;
      lb0_mem[col_tag] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
      if (pix_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb0_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb1_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pix_in;
      end
    end
  end

  assign p0         = win_q[0];
  assign p1         = win_q[1];
  assign p2         = win_q[2];
  assign p3         = win_q[3];
  assign p4         = win_q[4];
  assign p5         = win_q[5];
  assign p6         = win_q[6];
  assign p7         = win_q[7];
  assign p8         = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen: 4x4 and 3x3 instances share stimulus,
// expected windows come from a per-pixel image model pushed into a scoreboard.
module tb_sobel_window_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid, sof;
  logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic       a_wv, a_fd, b_wv, b_fd;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p0(a0), .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5), .p6(a6), .p7(a7), .p8(a8),
    .win_valid(a_wv), .frame_done(a_fd)
  );

  sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p0(b0), .p1(b1), .p2(b2), .p3(b3), .p4(b4), .p5(b5), .p6(b6), .p7(b7), .p8(b8),
    .win_valid(b_wv), .frame_done(b_fd)
  );

  typedef logic [8:0][7:0] win_vec_t;
  typedef struct packed {
    win_vec_t p;
    logic     fd;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         win_cnt = 0;
  int         fd_cnt = 0;
  bit         sel3 = 1'b0;
  int         mw = 4, mh = 4, mr = 0, mc = 0;
  logic [7:0] img [4][4];
  win_vec_t   act;
  logic       act_wv, act_fd;

  always_comb begin
    act    = sel3 ? {b8, b7, b6, b5, b4, b3, b2, b1, b0}
                  : {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    act_wv = sel3 ? b_wv : a_wv;
    act_fd = sel3 ? b_fd : a_fd;
  end

  // Scoreboard consumer: every window the DUT shows must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (act_wv === 1'b1) begin
        exp_t e;
        checks++;
        win_cnt++;
        if (act_fd === 1'b1) fd_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL win_unexpected act=%h fd=%b", act, act_fd);
        end else begin
          e = exp_q.pop_front();
          if (act !== e.p || act_fd !== e.fd) begin
            failures++;
            $display("FAIL win_values act=%h exp=%h fd_act=%b fd_exp=%b", act, e.p, act_fd, e.fd);
          end
        end
      end else if (act_fd !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL fd_without_window act=%b exp=0", act_fd);
      end
    end
  end

  task automatic send_pix(input logic [7:0] v, input logic s);
    int   r, c;
    exp_t e;
    r = s ? 0 : mr;
    c = s ? 0 : mc;
    img[r][c] = v;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) e.p[k] = img[r - 2 + k / 3][c - 2 + k % 3];
      e.fd = (r == mh - 1) && (c == mw - 1);
      exp_q.push_back(e);
    end
    if (c == mw - 1) begin
      mc = 0;
      mr = (r == mh - 1) ? 0 : r + 1;
    end else begin
      mc = c + 1;
      mr = r;
    end
    pix_in = v; sof = s; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit with_sof, input int first_idx);
    for (int i = first_idx; i < mw * mh; i++)
      send_pix(base + 8'(16 * (i / mw) + (i % mw)), with_sof && (i == 0));
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_q.delete();
    win_cnt = 0; fd_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    #12;
    checks++;
    if ({a8, a7, a6, a5, a4, a3, a2, a1, a0, a_wv, a_fd} !== '0) begin
      failures++;
      $display("FAIL reset_4x4 act=%h exp=0", {a8, a7, a6, a5, a4, a3, a2, a1, a0, a_wv, a_fd});
    end
    checks++;
    if ({b8, b7, b6, b5, b4, b3, b2, b1, b0, b_wv, b_fd} !== '0) begin
      failures++;
      $display("FAIL reset_3x3 act=%h exp=0", {b8, b7, b6, b5, b4, b3, b2, b1, b0, b_wv, b_fd});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic check_end(input string name, input int wins, input int fds);
    idle(2);
    checks++;
    if (win_cnt != wins || fd_cnt != fds || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_counts wins=%0d/%0d fd=%0d/%0d pending=%0d", name, win_cnt, wins,
               fd_cnt, fds, exp_q.size());
    end
  endtask

  task automatic test_ramp();
    win_vec_t first_w;
    first_w = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    model_reset();
    for (int i = 0; i < 16; i++) begin
      send_pix(8'(16 * (i / 4) + (i % 4)), i == 0);
      if (i == 10) begin
        checks++;
        if (act !== first_w || act_wv !== 1'b1) begin
          failures++;
          $display("FAIL ramp_first act=%h wv=%b exp=%h wv=1", act, act_wv, first_w);
        end
      end
    end
    checks++;
    if (act[8] !== 8'h33 || act[4] !== 8'h22 || act_fd !== 1'b1 || act_wv !== 1'b1) begin
      failures++;
      $display("FAIL ramp_last p8=%h p4=%h fd=%b wv=%b exp 33 22 1 1", act[8], act[4], act_fd, act_wv);
    end
    check_end("ramp", 4, 1);
  endtask

  task automatic test_stall();
    win_vec_t snap;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      send_pix(8'(16 * (i / 4) + (i % 4)), i == 0);
      snap = act;
      idle(1);
      checks++;
      if (act_wv !== 1'b0 || act !== snap) begin
        failures++;
        $display("FAIL stall_hold idx=%0d act=%h wv=%b exp=%h wv=0", i, act, act_wv, snap);
      end
    end
    check_end("stall", 4, 1);
  endtask

  task automatic test_back_to_back();
    model_reset();
    send_frame(8'h00, 1'b1, 0);
    send_pix(8'h80, 1'b0);
    checks++;
    if (win_cnt != 4 || fd_cnt != 1) begin
      failures++;
      $display("FAIL b2b_first_frame wins=%0d fd=%0d exp 4 1", win_cnt, fd_cnt);
    end
    send_frame(8'h80, 1'b0, 1);
    check_end("b2b", 8, 2);
  endtask

  task automatic test_sof_mid();
    model_reset();
    for (int i = 0; i < 6; i++) send_pix(8'h40 + 8'(16 * (i / 4) + (i % 4)), i == 0);
    send_pix(8'h00, 1'b1);
    checks++;
    if (act_fd !== 1'b0 || act_wv !== 1'b0) begin
      failures++;
      $display("FAIL sof_mid_restart fd=%b wv=%b exp 0 0", act_fd, act_wv);
    end
    send_frame(8'h00, 1'b0, 1);
    check_end("sof_mid", 4, 1);
  endtask

  task automatic test_reset_mid();
    model_reset();
    for (int i = 0; i < 11; i++) send_pix(8'(16 * (i / 4) + (i % 4)), i == 0);
    #5;
    checks++;
    if (exp_q.size() != 0 || win_cnt != 1) begin
      failures++;
      $display("FAIL rst_mid_pre pending=%0d wins=%0d exp 0 1", exp_q.size(), win_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0 || act_wv !== 1'b0 || act_fd !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_clear act=%h wv=%b fd=%b exp 0", act, act_wv, act_fd);
    end
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    send_frame(8'h00, 1'b1, 0);
    check_end("rst_mid", 4, 1);
  endtask

  task automatic test_small();
    sel3 = 1'b1; mw = 3; mh = 3;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      send_pix(8'(16 * (i / 3) + (i % 3)), i == 0);
      if (i == 8) begin
        checks++;
        if (act[4] !== 8'h11 || act_wv !== 1'b1 || act_fd !== 1'b1) begin
          failures++;
          $display("FAIL small_window p4=%h wv=%b fd=%b exp 11 1 1", act[4], act_wv, act_fd);
        end
      end
    end
    check_end("small", 1, 1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_back_to_back();
    test_sof_mid();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage directly upstream of the Sobel magnitude stage. It accepts one 8-bit grayscale pixel per valid cycle in row-major raster order and keeps two line buffers plus a 3x3 shift window. For every pixel position with a complete 3x3 neighbourhood it presents the nine neighbourhood pixels p0..p8, together with a valid strobe and frame bookkeeping. The p0..p8 outputs connect unchanged to the magnitude stage's p0..p8 inputs; p4 is provided for downstream consumers that need the centre pixel.

## Interface
- IMG_WIDTH, 256: pixels per line; must be ≥ 3; sets line-buffer depth.
- IMG_HEIGHT, 256: lines per frame; must be ≥ 3.
- clk  in  1  rising-edge clock; one clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  8  input pixel, unsigned.
- pix_valid  in  1  pix_in is accepted on this edge when high; no backpressure.
- sof  in  1  start of frame; qualified by pix_valid; marks the accepted pixel as (row 0, col 0).
- p0..p8  out  8 each  window pixels, registered.
- win_valid  out  1  p0..p8 hold a complete window this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame (row IMG_HEIGHT-1, col IMG_WIDTH-1) is accepted.

## Operation
- Counters:
  - col is 0..IMG_WIDTH-1 and row is 0..IMG_HEIGHT-1. Both are clog2-sized.
  - Each accepted pixel is tagged with the current (row, col). The counters then advance.
  - col wraps to 0 at IMG_WIDTH-1 and row increments. row wraps to 0 at IMG_HEIGHT-1.
- sof with pix_valid forces the accepted pixel to (0,0). The counters then become col=1, row=0. This applies mid-frame; the partial frame is abandoned and no frame_done is raised.
- Line buffers:
  - lb1 holds the previous line and lb0 holds the line before it. Both are addressed by col.
  - On an accepted pixel: read lb1[col] → a, read lb0[col] → b, write pix_in → lb1[col], write a → lb0[col]. This is read-before-write at the same address.
  - The buffers are not reset. Stale content is masked by the valid rule below.
- Window shift on an accepted pixel, each column shifting left:
  - top row: p0←p1, p1←p2, p2←b
  - middle row: p3←p4, p4←p5, p5←a
  - bottom row: p6←p7, p7←p8, p8←pix_in
- Mapping for an accepted pixel (r,c):
  - p0=(r-2,c-2), p1=(r-2,c-1), p2=(r-2,c)
  - p3=(r-1,c-2), p4=(r-1,c-1), p5=(r-1,c)
  - p6=(r,c-2), p7=(r,c-1), p8=(r,c)
  - The centre is therefore (r-1,c-1).
- Valid rule: win_valid is registered as pix_valid && row≥2 && col≥2, evaluated on the accepted pixel's tag.
  - The first two columns of each line and the first two rows of each frame produce no window.
  - Windows never straddle a line wrap.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses per complete frame.
- Stall: with pix_valid low, counters, line buffers and p0..p8 hold, and win_valid=0.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - p0..p8 = 0, win_valid = 0, frame_done = 0, col = 0, row = 0.
- Latency: 1 cycle. The window whose p8 is the pixel accepted at edge t is visible with win_valid=1 after edge t, for one cycle unless the next pixel is also valid.
- Throughput: one window per clock at 100% pix_valid.
- frame_done goes high after the same edge that accepts pixel (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the last win_valid, and lasts 1 cycle.
- sof and the last pixel on the same accepted pixel: sof wins, the pixel is tagged (0,0), and frame_done=0.
- Reset mid-frame: outputs clear immediately. The next frame must begin with sof or from (0,0) after reset.
- Downstream consumes p0..p8 only when win_valid=1. Its own pipeline latency is outside this block.

## Test plan
- Ramp frame, IMG_WIDTH=IMG_HEIGHT=4, pixel=16*r+c, continuous valid.
  - First win_valid is 1 cycle after pixel (2,2), with p0..p8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 windows; the last is p8=0x33, p4=0x22, with frame_done asserted on the same cycle.
- Same frame with pix_valid toggled 1-0-1.
  - Identical window sequence and values.
  - Outputs held and win_valid=0 on gap cycles.
- Back-to-back frames, second frame ramp+0x80.
  - Second frame windows contain only 0x80-based values.
  - Exactly 4 windows per frame, each frame ends with a frame_done pulse.
- sof asserted at pixel (1,2) of the first frame.
  - No frame_done. Counters restart there.
  - A full 4x4 frame follows with 4 correct windows.
- rst_n pulled low for 1 cycle mid-row 2, asynchronously between edges.
  - All outputs are 0 immediately.
  - The following frame, started with sof, yields the correct ramp windows.
- IMG_WIDTH=3, IMG_HEIGHT=3: exactly one window, centre p4=(1,1)=0x11, with frame_done on the same cycle.
